mux_rr_arbiter_32: RTL

MUX_RR_ARBITER_32 -- requirements
Module: mux_rr_arbiter_32

---
 rtl/mux_rr_arbiter_32.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter_32.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_32
//   Round-robin arbiter over 32 level-sensitive requesters that also steers a
//   32:1 data mux with the granted index.  A grant is held until the holder
//   pulses done, drops its request, or has held the grant for MAX_HOLD
//   cycles.  Every release is followed by at least one idle cycle before the
//   next arbitration.
//
// Parameters
//   MAX_HOLD  : maximum consecutive cycles a single grant is held (1..255)
//
// Ports
//   clk       : in  clock, all state updates on the rising edge
//   rst       : in  synchronous active-high reset
//   req[31:0] : in  level-sensitive request per source
//   done      : in  release pulse from the current grant holder
//   inp[31:0] : in  data lines feeding the 32:1 mux
//   sel[4:0]  : out registered index of the granted (or last granted) source
//   gnt[31:0] : out registered one-hot grant, zero while idle
//   gnt_valid : out high while a grant is held
//   OUT       : out registered inp[sel] while a grant is held, else 0
//   timeout   : out one-cycle pulse after a grant is revoked by the hold limit
// ---------------------------------------------------------------------------
module mux_rr_arbiter_32 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req,
   input  logic        done,
   input  logic [31:0] inp,
   output logic [4:0]  sel,
   output logic [31:0] gnt,
   output logic        gnt_valid,
   output logic        OUT,
   output logic        timeout
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   logic [0:0]  state_reg;
   logic [4:0]  sel_reg;
   logic [4:0]  ptr_reg;
   logic [31:0] gnt_reg;
   logic [7:0]  hold_reg;
   logic        out_reg;
   logic        timeout_reg;

   // ------------------------------------------------------------------
   // Arbitration: rotate the request vector so that bit 0 corresponds to
   // index ptr+1.  The lowest set bit of the rotated vector is then the
   // first requester in round-robin order; adding the offset back (mod 32)
   // gives the absolute winner.  The previous holder (ptr) lands in bit 31
   // and so has the lowest priority.
   // ------------------------------------------------------------------
   logic [4:0]  search_start;
   logic [31:0] req_rot;
   logic [4:0]  win_offset;
   logic [4:0]  winner;

   assign search_start = ptr_reg + 5'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rot
         assign req_rot[gi] = req[search_start + 5'(gi)];
      end
   endgenerate

   // Downward scan overwrites, so the lowest set bit wins.
   always_comb begin
      win_offset = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_offset = 5'(i);
         end
      end
   end

   assign winner = search_start + win_offset;

   // ------------------------------------------------------------------
   // Release conditions while in GRANT.  The hold-limit release only
   // reports a timeout when neither of the voluntary conditions is present.
   // ------------------------------------------------------------------
   logic rel_voluntary;
   logic rel_hold;
   logic release_now;

   assign rel_voluntary = done | ~req[sel_reg];
   assign rel_hold      = (hold_reg == HOLD_LIMIT);
   assign release_now   = rel_voluntary | rel_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         sel_reg     <= 5'd0;
         ptr_reg     <= 5'd31;   // first search after reset starts at index 0
         gnt_reg     <= 32'd0;
         hold_reg    <= 8'd0;
         out_reg     <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               out_reg     <= 1'b0;
               timeout_reg <= 1'b0;
               // done is deliberately ignored here
               if (|req) begin
                  state_reg <= ST_GRANT;
                  sel_reg   <= winner;
                  ptr_reg   <= winner;
                  gnt_reg   <= 32'd1 << winner;
                  hold_reg  <= 8'd1;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  // sel_reg keeps the released index
                  state_reg   <= ST_IDLE;
                  gnt_reg     <= 32'd0;
                  hold_reg    <= 8'd0;
                  out_reg     <= 1'b0;
                  timeout_reg <= rel_hold & ~rel_voluntary;
               end else begin
                  // Mux output trails the applied select by one register.
                  out_reg     <= inp[sel_reg];
                  timeout_reg <= 1'b0;
                  if (hold_reg != 8'hFF) begin
                     hold_reg <= hold_reg + 8'd1;
                  end
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               gnt_reg     <= 32'd0;
               hold_reg    <= 8'd0;
               out_reg     <= 1'b0;
               timeout_reg <= 1'b0;
            end
         endcase
      end
   end

   assign sel       = sel_reg;
   assign gnt       = gnt_reg;
   assign gnt_valid = (state_reg == ST_GRANT);
   assign OUT       = out_reg;
   assign timeout   = timeout_reg;

endmodule
